// File: rtl/ifetch_buffer.sv
`timescale 1ns/1ps
// ifetch_buffer
//   Instruction return buffer between the fetch OBI port and decode. Granted
//   fetch addresses are tracked in an address FIFO. Each returning response
//   is paired with the oldest outstanding address, and the resulting
//   {pc, instr} entry is queued for decode. A squash empties the queue and
//   marks every still-outstanding request for discard. Credit back-pressure
//   (stall_ao) keeps in-flight plus queued entries within DEPTH.
//
//   Optional feature: define LUCID64_IBUF_BYPASS_EN to let a response that
//   lands on an empty queue drive the outputs in the same cycle.
//
// Parameters
//   DEPTH          total entries (in-flight + queued); power of two, >= 2
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   squash_i       drop queue and all in-flight responses
//   stall_i        decode stall; head entry held
//   imem_req_i     tap of fetch OBI request
//   imem_gnt_i     OBI grant
//   imem_addr_i    tap of fetch OBI address (64b)
//   imem_rvalid_i  OBI response valid
//   imem_rdata_i   OBI response data (32b)
//   stall_ao       no credit: fetch must not issue a request
//   valid_o        head entry valid
//   instr_o        head instruction word
//   pc_o           head PC
//   next_pc_o      head PC + 4
module ifetch_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        squash_i,
  input  logic        stall_i,
  input  logic        imem_req_i,
  input  logic        imem_gnt_i,
  input  logic [63:0] imem_addr_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        stall_ao,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic [63:0] next_pc_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Address FIFO state
  logic [63:0]   addr_q [DEPTH];
  logic [63:0]   addr_d [DEPTH];
  logic [PW-1:0] aw_ptr_q, aw_ptr_d;
  logic [PW-1:0] ar_ptr_q, ar_ptr_d;
  logic [CW-1:0] outst_q, outst_d;

  // Instruction queue state
  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] qw_ptr_q, qw_ptr_d;
  logic [PW-1:0] qr_ptr_q, qr_ptr_d;
  logic [CW-1:0] qcnt_q, qcnt_d;

  // Squash bookkeeping and credit
  logic [CW-1:0] discard_q, discard_d;
  logic          stall_q, stall_d;

  // Handshake decode
  logic          addr_push;
  logic          rsp_ok;
  logic          rsp_keep;
  logic          head_pop;
  logic          q_push;
  logic          bypass_c;
  entry_t        rsp_ent;
  entry_t        out_ent;
  logic          out_valid_c;

  // Event decode; a response with nothing outstanding is ignored entirely
  always_comb begin
    addr_push = imem_req_i & imem_gnt_i & (outst_q != CNT_FULL);
    rsp_ok    = imem_rvalid_i & (outst_q != CNT_ZERO);
    rsp_keep  = rsp_ok & (discard_q == CNT_ZERO) & ~squash_i;
    head_pop  = (qcnt_q != CNT_ZERO) & ~stall_i & ~squash_i;
    rsp_ent   = '{pc: addr_q[ar_ptr_q], instr: imem_rdata_i};
`ifdef LUCID64_IBUF_BYPASS_EN
    // Response on an empty queue goes straight out; stored only if decode stalls
    bypass_c  = rsp_keep & (qcnt_q == CNT_ZERO);
    q_push    = rsp_keep & ~(bypass_c & ~stall_i);
`else
    bypass_c  = 1'b0;
    q_push    = rsp_keep;
`endif
    // A full queue only accepts a push in the cycle it pops
    q_push    = q_push & ((qcnt_q != CNT_FULL) | head_pop);
  end

  // Address FIFO next state
  always_comb begin
    addr_d   = addr_q;
    aw_ptr_d = aw_ptr_q;
    ar_ptr_d = ar_ptr_q;
    outst_d  = outst_q;
    if (addr_push) begin
      addr_d[aw_ptr_q] = imem_addr_i;
      aw_ptr_d         = aw_ptr_q + PW'(1);
    end
    if (rsp_ok) begin
      ar_ptr_d = ar_ptr_q + PW'(1);
    end
    case ({addr_push, rsp_ok})
      2'b10:   outst_d = outst_q + CNT_ONE;
      2'b01:   outst_d = outst_q - CNT_ONE;
      default: outst_d = outst_q;
    endcase
  end

  // Instruction queue, discard counter and credit next state
  always_comb begin
    ent_d     = ent_q;
    qw_ptr_d  = qw_ptr_q;
    qr_ptr_d  = qr_ptr_q;
    qcnt_d    = qcnt_q;
    discard_d = discard_q;
    if (q_push) begin
      ent_d[qw_ptr_q] = rsp_ent;
      qw_ptr_d        = qw_ptr_q + PW'(1);
    end
    if (head_pop) begin
      qr_ptr_d = qr_ptr_q + PW'(1);
    end
    case ({q_push, head_pop})
      2'b10:   qcnt_d = qcnt_q + CNT_ONE;
      2'b01:   qcnt_d = qcnt_q - CNT_ONE;
      default: qcnt_d = qcnt_q;
    endcase
    if (rsp_ok && (discard_q != CNT_ZERO)) begin
      discard_d = discard_q - CNT_ONE;
    end
    // Squash: every request still in flight after this edge will be dropped,
    // including one granted now; a response returning now is already popped
    if (squash_i) begin
      qcnt_d    = CNT_ZERO;
      qr_ptr_d  = qw_ptr_q;
      discard_d = outst_d;
    end
    stall_d = (SW'(outst_d) + SW'(qcnt_d)) >= SW'(DEPTH);
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '{default: '0};
      aw_ptr_q  <= '0;
      ar_ptr_q  <= '0;
      outst_q   <= '0;
      ent_q     <= '{default: '0};
      qw_ptr_q  <= '0;
      qr_ptr_q  <= '0;
      qcnt_q    <= '0;
      discard_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      aw_ptr_q  <= aw_ptr_d;
      ar_ptr_q  <= ar_ptr_d;
      outst_q   <= outst_d;
      ent_q     <= ent_d;
      qw_ptr_q  <= qw_ptr_d;
      qr_ptr_q  <= qr_ptr_d;
      qcnt_q    <= qcnt_d;
      discard_q <= discard_d;
      stall_q   <= stall_d;
    end
  end

  // Head entry outputs; zeroed when nothing is valid so reset shows all zero
  always_comb begin
    out_valid_c = (qcnt_q != CNT_ZERO) | bypass_c;
    out_ent     = bypass_c ? rsp_ent : ent_q[qr_ptr_q];
    valid_o     = out_valid_c;
    pc_o        = out_valid_c ? out_ent.pc : 64'd0;
    instr_o     = out_valid_c ? out_ent.instr : 32'd0;
    next_pc_o   = out_valid_c ? (out_ent.pc + 64'd4) : 64'd0;
  end

  assign stall_ao = stall_q;

`ifndef SYNTHESIS
  // Until the first grant after reset, stray responses belong to requests
  // issued before reset and are legitimately ignored.
  logic orphan_ok_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      orphan_ok_q <= 1'b1;
    end else if (imem_req_i && imem_gnt_i) begin
      orphan_ok_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(imem_req_i && imem_gnt_i && stall_ao))
        else $error("ifetch_buffer: grant while stall_ao is high");
      assert (!(imem_rvalid_i && (outst_q == CNT_ZERO) && !orphan_ok_q))
        else $error("ifetch_buffer: rvalid with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for ifetch_buffer: directed scenarios plus a randomized
// credit-respecting stream. Expected entries are queued when a response is
// driven and compared whenever decode consumes the head.
module tb_ifetch_buffer;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk_i;
  logic        rst_ni;
  logic        squash_i;
  logic        stall_i;
  logic        imem_req_i;
  logic        imem_gnt_i;
  logic [63:0] imem_addr_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_ao;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic [63:0] next_pc_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ent_t        sb[$];
  logic [63:0] aq[$];

  ifetch_buffer #(.DEPTH(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .squash_i     (squash_i),
    .stall_i      (stall_i),
    .imem_req_i   (imem_req_i),
    .imem_gnt_i   (imem_gnt_i),
    .imem_addr_i  (imem_addr_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_ao     (stall_ao),
    .valid_o      (valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .next_pc_o    (next_pc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic g, input logic [63:0] a, input logic rv,
                     input logic [31:0] rd, input logic stl, input logic sq);
    imem_req_i    = g;
    imem_gnt_i    = g;
    imem_addr_i   = a;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    stall_i       = stl;
    squash_i      = sq;
  endtask

  // Advance to the next cycle and drive its inputs
  task automatic drv(input logic g, input logic [63:0] a, input logic rv,
                     input logic [31:0] rd, input logic stl, input logic sq);
    @(posedge clk_i);
    #1;
    put(g, a, rv, rd, stl, sq);
  endtask

  task automatic expect_entry(input logic [63:0] pc, input logic [31:0] instr);
    sb.push_back('{pc: pc, instr: instr});
  endtask

  // Consume monitor: compare each head that decode takes
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && !stall_i) begin
      chk("sb_avail", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        ent_t e;
        e = sb.pop_front();
        chk("sb_pc", pc_o, e.pc);
        chk("sb_instr", 64'(instr_o), 64'(e.instr));
        chk("sb_next_pc", next_pc_o, e.pc + 64'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    put(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_pc", pc_o, 64'd0);
    chk("rst_next_pc", next_pc_o, 64'd0);
    chk("rst_instr", 64'(instr_o), 64'd0);
    chk("rst_stall", 64'(stall_ao), 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Basic fetch: grant, response, entry
    drv(1'b1, 64'h8000_0000, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t1_stall_c1", 64'(stall_ao), 64'd0);
    chk("t1_valid_c1", 64'(valid_o), 64'd0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
    expect_entry(64'h8000_0000, 32'h13);
    #3 chk("t1_stall_c2", 64'(stall_ao), 64'd0);
`ifdef LUCID64_IBUF_BYPASS_EN
    chk("t1_valid_c2", 64'(valid_o), 64'd1);
    chk("t1_pc_c2", pc_o, 64'h8000_0000);
`else
    chk("t1_valid_c2", 64'(valid_o), 64'd0);
`endif
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t1_stall_c3", 64'(stall_ao), 64'd0);
`ifdef LUCID64_IBUF_BYPASS_EN
    chk("t1_valid_c3", 64'(valid_o), 64'd0);
`else
    chk("t1_valid_c3", 64'(valid_o), 64'd1);
    chk("t1_pc_c3", pc_o, 64'h8000_0000);
    chk("t1_next_pc_c3", next_pc_o, 64'h8000_0004);
    chk("t1_instr_c3", 64'(instr_o), 64'h13);
`endif

    // Latency of a response landing on an empty queue
    drv(1'b1, 64'h800, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
    expect_entry(64'h800, 32'h33);
`ifdef LUCID64_IBUF_BYPASS_EN
    #3 chk("t6_valid_same", 64'(valid_o), 64'd1);
    chk("t6_instr_same", 64'(instr_o), 64'h33);
`else
    #3 chk("t6_valid_same", 64'(valid_o), 64'd0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t6_valid_next", 64'(valid_o), 64'd1);
    chk("t6_instr_next", 64'(instr_o), 64'h33);
`endif
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Stalled decode fills the buffer and removes credit
    drv(1'b1, 64'h100, 1'b0, 32'd0, 1'b1, 1'b0);
    #3 chk("t2_stall_g0", 64'(stall_ao), 64'd0);
    drv(1'b1, 64'h104, 1'b0, 32'd0, 1'b1, 1'b0);
    #3 chk("t2_stall_g1", 64'(stall_ao), 64'd0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    #3 chk("t2_stall_full", 64'(stall_ao), 64'd1);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_000A, 1'b1, 1'b0);
    expect_entry(64'h100, 32'hA);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_000B, 1'b1, 1'b0);
    expect_entry(64'h104, 32'hB);
    #3 chk("t2_stall_rsp", 64'(stall_ao), 64'd1);
    chk("t2_valid_rsp", 64'(valid_o), 64'd1);
    chk("t2_pc_rsp", pc_o, 64'h100);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    #3 chk("t2_stall_hold", 64'(stall_ao), 64'd1);
    chk("t2_pc_hold", pc_o, 64'h100);
    chk("t2_instr_hold", 64'(instr_o), 64'hA);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t2_pc_release", pc_o, 64'h100);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t2_pc_second", pc_o, 64'h104);
    chk("t2_instr_second", 64'(instr_o), 64'hB);
    chk("t2_stall_second", 64'(stall_ao), 64'd0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t2_valid_empty", 64'(valid_o), 64'd0);

    // Squash with the first of two responses
    drv(1'b1, 64'h300, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b1, 64'h304, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_1111, 1'b0, 1'b1);
    #3 chk("t3_valid_sq", 64'(valid_o), 64'd0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_2222, 1'b0, 1'b0);
    #3 chk("t3_valid_drop", 64'(valid_o), 64'd0);
    chk("t3_stall_drop", 64'(stall_ao), 64'd0);
    drv(1'b1, 64'h200, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t3_valid_g", 64'(valid_o), 64'd0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0099, 1'b0, 1'b0);
    expect_entry(64'h200, 32'h99);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Squash with one queued entry and a grant in the squash cycle
    drv(1'b1, 64'h400, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0044, 1'b1, 1'b0);
    drv(1'b1, 64'h500, 1'b0, 32'd0, 1'b1, 1'b1);
    #3 chk("t4_valid_sq", 64'(valid_o), 64'd1);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t4_valid_after", 64'(valid_o), 64'd0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
    #3 chk("t4_valid_drop", 64'(valid_o), 64'd0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t4_valid_post", 64'(valid_o), 64'd0);
    drv(1'b1, 64'h600, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0066, 1'b0, 1'b0);
    expect_entry(64'h600, 32'h66);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Mid-stream reset with two queued entries
    drv(1'b1, 64'h700, 1'b0, 32'd0, 1'b1, 1'b0);
    drv(1'b1, 64'h704, 1'b0, 32'd0, 1'b1, 1'b0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0077, 1'b1, 1'b0);
    drv(1'b0, 64'd0, 1'b1, 32'h0000_0078, 1'b1, 1'b0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    #3 chk("t5_valid_pre", 64'(valid_o), 64'd1);
    chk("t5_pc_pre", pc_o, 64'h700);
    rst_ni = 1'b0;
    #1 chk("t5_valid_rst", 64'(valid_o), 64'd0);
    chk("t5_pc_rst", pc_o, 64'd0);
    chk("t5_instr_rst", 64'(instr_o), 64'd0);
    chk("t5_next_pc_rst", next_pc_o, 64'd0);
    chk("t5_stall_rst", 64'(stall_ao), 64'd0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    drv(1'b0, 64'd0, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    #3 chk("t5_valid_late", 64'(valid_o), 64'd0);
    drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("t5_valid_late_next", 64'(valid_o), 64'd0);

    // Randomized stream respecting credit
    for (int c = 0; c < 80; c++) begin
      logic        g;
      logic        rv;
      logic        stl;
      logic [63:0] a;
      logic [31:0] d;
      @(posedge clk_i);
      #1;
      chk("rand_credit", 64'(stall_ao), 64'((aq.size() + sb.size()) >= 2));
      g   = !stall_ao && ($urandom_range(0, 2) != 0);
      rv  = (aq.size() != 0) && ($urandom_range(0, 2) != 0);
      stl = ($urandom_range(0, 3) == 0);
      a   = {$urandom, $urandom} & ~64'd3;
      d   = $urandom;
      if (rv) begin
        logic [63:0] ra;
        ra = aq.pop_front();
        expect_entry(ra, d);
      end
      if (g) aq.push_back(a);
      put(g, a, rv, d, stl, 1'b0);
    end

    // Drain outstanding responses, then let decode empty the queue
    while (aq.size() != 0) begin
      logic [63:0] ra;
      logic [31:0] d;
      @(posedge clk_i);
      #1;
      ra = aq.pop_front();
      d  = $urandom;
      expect_entry(ra, d);
      put(1'b0, 64'd0, 1'b1, d, 1'b0, 1'b0);
    end
    repeat (4) drv(1'b0, 64'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #3 chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_valid", 64'(valid_o), 64'd0);
    chk("drain_stall", 64'(stall_ao), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
